// File: rtl/vga_timing_gen.sv
// Two-mode VGA raster timing generator with pixel clock-enable and registered, pixel-aligned outputs.
// Mode 1 and frame-boundary mode switching are built only when VGA_TIMING_MODESEL_EN is defined.
module vga_timing_gen #(
    parameter int HW           = 11,
    parameter int VW           = 10,
    parameter int H_DISPLAY    = 1024,
    parameter int H_FRONT      = 24,
    parameter int H_SYNC       = 136,
    parameter int H_BACK       = 160,
    parameter int V_DISPLAY    = 768,
    parameter int V_BOTTOM     = 3,
    parameter int V_SYNC       = 6,
    parameter int V_TOP        = 29,
    parameter bit H_SYNC_POL   = 1'b0,
    parameter bit V_SYNC_POL   = 1'b0,
    parameter int A_H_DISPLAY  = 640,
    parameter int A_H_FRONT    = 16,
    parameter int A_H_SYNC     = 96,
    parameter int A_H_BACK     = 48,
    parameter int A_V_DISPLAY  = 480,
    parameter int A_V_BOTTOM   = 10,
    parameter int A_V_SYNC     = 2,
    parameter int A_V_TOP      = 33,
    parameter bit A_H_SYNC_POL = 1'b0,
    parameter bit A_V_SYNC_POL = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          mode_sel,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          line_start,
    output logic          frame_start,
    output logic          active_mode
);

    localparam logic [HW-1:0] M0_H_MAX    = HW'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [HW-1:0] M0_H_DISP   = HW'(H_DISPLAY);
    localparam logic [HW-1:0] M0_HS_START = HW'(H_DISPLAY + H_FRONT);
    localparam logic [HW-1:0] M0_HS_END   = HW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] M0_V_MAX    = VW'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
    localparam logic [VW-1:0] M0_V_DISP   = VW'(V_DISPLAY);
    localparam logic [VW-1:0] M0_VS_START = VW'(V_DISPLAY + V_BOTTOM);
    localparam logic [VW-1:0] M0_VS_END   = VW'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

`ifdef VGA_TIMING_MODESEL_EN
    localparam logic [HW-1:0] M1_H_MAX    = HW'(A_H_DISPLAY + A_H_FRONT + A_H_SYNC + A_H_BACK - 1);
    localparam logic [HW-1:0] M1_H_DISP   = HW'(A_H_DISPLAY);
    localparam logic [HW-1:0] M1_HS_START = HW'(A_H_DISPLAY + A_H_FRONT);
    localparam logic [HW-1:0] M1_HS_END   = HW'(A_H_DISPLAY + A_H_FRONT + A_H_SYNC - 1);
    localparam logic [VW-1:0] M1_V_MAX    = VW'(A_V_DISPLAY + A_V_BOTTOM + A_V_SYNC + A_V_TOP - 1);
    localparam logic [VW-1:0] M1_V_DISP   = VW'(A_V_DISPLAY);
    localparam logic [VW-1:0] M1_VS_START = VW'(A_V_DISPLAY + A_V_BOTTOM);
    localparam logic [VW-1:0] M1_VS_END   = VW'(A_V_DISPLAY + A_V_BOTTOM + A_V_SYNC - 1);
    localparam bit            M1_H_POL    = A_H_SYNC_POL;
    localparam bit            M1_V_POL    = A_V_SYNC_POL;
`else
    // Single-mode build: mode 1 aliases mode 0 so the muxes below fold away.
    localparam logic [HW-1:0] M1_H_MAX    = M0_H_MAX;
    localparam logic [HW-1:0] M1_H_DISP   = M0_H_DISP;
    localparam logic [HW-1:0] M1_HS_START = M0_HS_START;
    localparam logic [HW-1:0] M1_HS_END   = M0_HS_END;
    localparam logic [VW-1:0] M1_V_MAX    = M0_V_MAX;
    localparam logic [VW-1:0] M1_V_DISP   = M0_V_DISP;
    localparam logic [VW-1:0] M1_VS_START = M0_VS_START;
    localparam logic [VW-1:0] M1_VS_END   = M0_VS_END;
    localparam bit            M1_H_POL    = H_SYNC_POL;
    localparam bit            M1_V_POL    = V_SYNC_POL;

    logic        unused_mode_sel;
    logic [31:0] unused_a_params;
    assign unused_mode_sel = mode_sel;
    assign unused_a_params = 32'(A_H_DISPLAY + A_H_FRONT + A_H_SYNC + A_H_BACK + A_V_DISPLAY
                                 + A_V_BOTTOM + A_V_SYNC + A_V_TOP + int'(A_H_SYNC_POL)
                                 + int'(A_V_SYNC_POL));
`endif

    logic [HW-1:0] hpos_q, hpos_d;
    logic [VW-1:0] vpos_q, vpos_d;
    logic          mode_q, mode_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          disp_q, disp_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    logic          h_wrap, v_wrap;
    logic [HW-1:0] cur_h_max, nxt_h_disp, nxt_hs_start, nxt_hs_end;
    logic [VW-1:0] cur_v_max, nxt_v_disp, nxt_vs_start, nxt_vs_end;
    logic          nxt_h_pol, nxt_v_pol;

    always_comb begin
        hpos_d        = hpos_q;
        vpos_d        = vpos_q;
        mode_d        = mode_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        disp_d        = disp_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        // Wrap detection uses the mode of the frame being scanned out.
        cur_h_max = mode_q ? M1_H_MAX : M0_H_MAX;
        cur_v_max = mode_q ? M1_V_MAX : M0_V_MAX;
        h_wrap    = (hpos_q == cur_h_max);
        v_wrap    = (vpos_q == cur_v_max);

        if (ce) begin
            hpos_d = h_wrap ? '0 : hpos_q + HW'(1);
            if (h_wrap) begin
                vpos_d = v_wrap ? '0 : vpos_q + VW'(1);
            end
            if (h_wrap && v_wrap) begin
`ifdef VGA_TIMING_MODESEL_EN
                mode_d = mode_sel;
`else
                mode_d = 1'b0;
`endif
            end
        end

        // Decode looks at the post-edge position and mode so every output matches hpos/vpos.
        nxt_h_disp   = mode_d ? M1_H_DISP   : M0_H_DISP;
        nxt_hs_start = mode_d ? M1_HS_START : M0_HS_START;
        nxt_hs_end   = mode_d ? M1_HS_END   : M0_HS_END;
        nxt_v_disp   = mode_d ? M1_V_DISP   : M0_V_DISP;
        nxt_vs_start = mode_d ? M1_VS_START : M0_VS_START;
        nxt_vs_end   = mode_d ? M1_VS_END   : M0_VS_END;
        nxt_h_pol    = mode_d ? M1_H_POL    : H_SYNC_POL;
        nxt_v_pol    = mode_d ? M1_V_POL    : V_SYNC_POL;

        if (ce) begin
            hsync_d       = (hpos_d >= nxt_hs_start && hpos_d <= nxt_hs_end) ? nxt_h_pol : ~nxt_h_pol;
            vsync_d       = (vpos_d >= nxt_vs_start && vpos_d <= nxt_vs_end) ? nxt_v_pol : ~nxt_v_pol;
            disp_d        = (hpos_d < nxt_h_disp) && (vpos_d < nxt_v_disp);
            line_start_d  = (hpos_d == '0);
            frame_start_d = (hpos_d == '0) && (vpos_d == '0);
        end
    end

    // Reset parks the raster on the last pixel of a mode 0 frame so the first ce lands on (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q        <= M0_H_MAX;
            vpos_q        <= M0_V_MAX;
            mode_q        <= 1'b0;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            disp_q        <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            mode_q        <= mode_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            disp_q        <= disp_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign active_mode = mode_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = disp_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using shrunken rasters: a linear-pixel-index model checks every cycle,
// and literal expectations pin the model at hand-computed raster positions.
module tb_vga_timing_gen;

    localparam int HW = 5;
    localparam int VW = 4;
    // Mode 0: 8/2/3/2 x 6/1/2/2 -> 15 x 11, hsync 10..12, vsync 7..8 (vsync active high)
    // Mode 1: 5/1/2/1 x 4/1/1/2 -> 9 x 8, hsync 6..7 (active high), vsync 5..5
    localparam int HD[2] = '{8, 5};
    localparam int HF[2] = '{2, 1};
    localparam int HS[2] = '{3, 2};
    localparam int HB[2] = '{2, 1};
    localparam int VD[2] = '{6, 4};
    localparam int VB[2] = '{1, 1};
    localparam int VS[2] = '{2, 1};
    localparam int VT[2] = '{2, 2};
    localparam bit HP[2] = '{1'b0, 1'b1};
    localparam bit VP[2] = '{1'b1, 1'b0};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ce = 1'b0;
    logic          mode_sel = 1'b0;
    logic          hsync, vsync, display_on, line_start, frame_start, active_mode;
    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;

    int checks = 0;
    int passed = 0;

    vga_timing_gen #(
        .HW(HW), .VW(VW),
        .H_DISPLAY(HD[0]), .H_FRONT(HF[0]), .H_SYNC(HS[0]), .H_BACK(HB[0]),
        .V_DISPLAY(VD[0]), .V_BOTTOM(VB[0]), .V_SYNC(VS[0]), .V_TOP(VT[0]),
        .H_SYNC_POL(HP[0]), .V_SYNC_POL(VP[0]),
        .A_H_DISPLAY(HD[1]), .A_H_FRONT(HF[1]), .A_H_SYNC(HS[1]), .A_H_BACK(HB[1]),
        .A_V_DISPLAY(VD[1]), .A_V_BOTTOM(VB[1]), .A_V_SYNC(VS[1]), .A_V_TOP(VT[1]),
        .A_H_SYNC_POL(HP[1]), .A_V_SYNC_POL(VP[1])
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .mode_sel(mode_sel),
        .hsync(hsync), .vsync(vsync), .display_on(display_on),
        .hpos(hpos), .vpos(vpos),
        .line_start(line_start), .frame_start(frame_start), .active_mode(active_mode)
    );

    always #5 clk = ~clk;

    function automatic int htot(int m);
        return HD[m] + HF[m] + HS[m] + HB[m];
    endfunction

    function automatic int vtot(int m);
        return VD[m] + VB[m] + VS[m] + VT[m];
    endfunction

    // Model: position is a linear pixel index within the frame plus the frame's mode.
    int m_p = 0;
    int m_mode = 0;
    bit m_rst = 1'b0;
    bit m_adv = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_rst   = 1'b1;
            m_mode  = 0;
            m_adv   = 1'b0;
        end else if (ce) begin
            if (m_rst || m_p == htot(m_mode) * vtot(m_mode) - 1) begin
                m_p = 0;
`ifdef VGA_TIMING_MODESEL_EN
                m_mode = int'(mode_sel);
`else
                m_mode = 0;
`endif
            end else begin
                m_p = m_p + 1;
            end
            m_rst = 1'b0;
            m_adv = 1'b1;
        end else begin
            m_adv = 1'b0;
        end
    end

    function automatic logic [14:0] expected();
        int h, v, m, hs0, vs0;
        logic ehs, evs;
        if (m_rst)
            return {5'(htot(0) - 1), 4'(vtot(0) - 1), ~HP[0], ~VP[0], 1'b0, 1'b0, 1'b0, 1'b0};
        m   = m_mode;
        h   = m_p % htot(m);
        v   = m_p / htot(m);
        hs0 = HD[m] + HF[m];
        vs0 = VD[m] + VB[m];
        ehs = (h >= hs0 && h < hs0 + HS[m]) ? HP[m] : ~HP[m];
        evs = (v >= vs0 && v < vs0 + VS[m]) ? VP[m] : ~VP[m];
        return {5'(h), 4'(v), ehs, evs, (h < HD[m]) && (v < VD[m]),
                m_adv && h == 0, m_adv && h == 0 && v == 0, 1'(m)};
    endfunction

    always @(negedge clk) begin
        logic [14:0] got, exp_v;
        if (m_valid) begin
            got   = {hpos, vpos, hsync, vsync, display_on, line_start, frame_start, active_mode};
            exp_v = expected();
            checks++;
            if (got === exp_v) passed++;
            else $display("FAIL cycle_model t=%0t got=%h expected=%h (hpos,vpos,hs,vs,de,ls,fs,am)",
                          $time, got, exp_v);
        end
    end

    task automatic lit(input string nm, input int got, input int exp_v);
        checks++;
        if (got == exp_v) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp_v);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit_reset_state(input string tag);
        lit({tag, "_hpos"}, int'(hpos), 14);
        lit({tag, "_vpos"}, int'(vpos), 10);
        lit({tag, "_hsync"}, int'(hsync), 1);
        lit({tag, "_vsync"}, int'(vsync), 0);
        lit({tag, "_de"}, int'(display_on), 0);
        lit({tag, "_fs"}, int'(frame_start), 0);
        lit({tag, "_am"}, int'(active_mode), 0);
    endtask

    initial begin
        step(3);
        lit_reset_state("reset");
        lit("reset_ls", int'(line_start), 0);

        reset = 1'b0; ce = 1'b1;
        step(1);
        lit("first_hpos", int'(hpos), 0);
        lit("first_vpos", int'(vpos), 0);
        lit("first_fs", int'(frame_start), 1);
        lit("first_ls", int'(line_start), 1);
        lit("first_de", int'(display_on), 1);
        lit("first_hsync", int'(hsync), 1);
        lit("first_vsync", int'(vsync), 0);
        step(10);
        lit("h10_hsync", int'(hsync), 0);
        lit("h10_de", int'(display_on), 0);
        step(3);
        lit("h13_hsync", int'(hsync), 1);
        step(2);
        lit("line1_vpos", int'(vpos), 1);
        lit("line1_ls", int'(line_start), 1);
        lit("line1_fs", int'(frame_start), 0);
        step(90);
        lit("v7_vsync", int'(vsync), 1);
        lit("v7_de", int'(display_on), 0);
        step(60);
        lit("frame2_fs", int'(frame_start), 1);
        lit("frame2_hpos", int'(hpos), 0);

        mode_sel = 1'b1;
        step(100);
        lit("midframe_am", int'(active_mode), 0);
        step(65);
        lit("switch_fs", int'(frame_start), 1);
`ifdef VGA_TIMING_MODESEL_EN
        lit("switch_am", int'(active_mode), 1);
        mode_sel = 1'b0;
        step(7);
        lit("m1_h7_hsync", int'(hsync), 1);
        step(65);
        lit("m1_back_fs", int'(frame_start), 1);
        lit("m1_back_am", int'(active_mode), 0);
`else
        lit("switch_am", int'(active_mode), 0);
        mode_sel = 1'b0;
`endif

        for (int i = 0; i < 200; i++) begin
            ce = ~ce;
            step(1);
        end
        for (int i = 0; i < 400; i++) begin
            ce       = 1'($urandom_range(0, 1));
            mode_sel = 1'($urandom_range(0, 1));
            step(1);
        end

        mode_sel = 1'b0; ce = 1'b1;
        step(37);
        reset = 1'b1;
        step(1);
        lit_reset_state("midreset");
        step(3);
        lit_reset_state("heldreset");
        reset = 1'b0;
        step(1);
        lit("post_reset_fs", int'(frame_start), 1);
        lit("post_reset_hpos", int'(hpos), 0);
        lit("post_reset_vpos", int'(vpos), 0);
        ce = 1'b0;
        step(1);
        lit("hold_fs", int'(frame_start), 0);
        lit("hold_ls", int'(line_start), 0);
        lit("hold_hpos", int'(hpos), 0);
        lit("hold_de", int'(display_on), 1);
        ce = 1'b1;
        step(400);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
